// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
// Shared definitions for the serial 1011 pattern detector:
//   state_t       - 2-bit FSM state type, S0..S3 = length of the matched prefix
//   PATTERN       - detected pattern, MSB is the first bit to arrive
//   CNT_W_DEFAULT - default width of the detection and bit counters
package seq_detect_pkg;

   typedef enum logic [1:0] {
      S0 = 2'b00,  // nothing matched
      S1 = 2'b01,  // matched 1
      S2 = 2'b10,  // matched 10
      S3 = 2'b11   // matched 101
   } state_t;

   localparam logic [3:0] PATTERN = 4'b1011;

   localparam int unsigned CNT_W_DEFAULT = 8;

endpackage

// File: rtl/seq_out_fn.sv
// seq_out_fn
// Combinational Mealy output of the 1011 detector.
// Ports:
//   fire      - input, a bit is consumed this cycle (in_valid & in_ready)
//   in        - input, serial data bit
//   currstate - input, current FSM state
//   nxtout    - output, high when the consumed bit completes the pattern
module seq_out_fn
   import seq_detect_pkg::*;
(
   input  logic   fire,
   input  logic   in,
   input  state_t currstate,
   output logic   nxtout
);

   // S3 already holds the first three pattern bits; the last one completes it.
   assign nxtout = fire & (currstate == S3) & (in == PATTERN[0]);

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
// Controller for the serial 1011 pattern detector: state register, next-state
// logic, input handshake and detection bookkeeping.
// Build option: define SEQDET_OVERLAP_EN to let detections overlap (the
// trailing 1 of a match starts the next one); undefined, matching restarts.
// Ports:
//   clk       - input, system clock, rising edge
//   rst_n     - input, asynchronous active-low reset
//   in_valid  - input, serial bit presented
//   in        - input, serial data bit
//   in_ready  - output, block accepts a bit (low during clear)
//   clear     - input, synchronous clear of state and counters
//   currstate - output [1:0], current FSM state
//   nxtout    - output, combinational detect for the bit being consumed
//   det_pulse - output, registered nxtout
//   det_count - output [CNT_W-1:0], detections, saturating
//   bit_count - output [CNT_W-1:0], consumed bits, wrapping
module seq_detect_ctrl
   import seq_detect_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in,
   output logic             in_ready,
   input  logic             clear,
   output logic [1:0]       currstate,
   output logic             nxtout,
   output logic             det_pulse,
   output logic [CNT_W-1:0] det_count,
   output logic [CNT_W-1:0] bit_count
);

   state_t state_q;
   state_t state_d;
   logic   fire;

   assign in_ready  = ~clear;
   assign fire      = in_valid & in_ready;
   assign currstate = state_q;

   seq_out_fn u_out_fn (
      .fire      (fire),
      .in        (in),
      .currstate (state_q),
      .nxtout    (nxtout)
   );

   always_comb begin
      state_d = state_q;
      if (fire) begin
         unique case (state_q)
            S0: state_d = in ? S1 : S0;
            S1: state_d = in ? S1 : S2;
            S2: state_d = in ? S3 : S0;
            S3: begin
               if (in) begin
`ifdef SEQDET_OVERLAP_EN
                  state_d = S1;
`else
                  state_d = S0;
`endif
               end else begin
                  state_d = S2;
               end
            end
            default: state_d = S0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S0;
         det_pulse <= 1'b0;
         det_count <= '0;
         bit_count <= '0;
      end else if (clear) begin
         state_q   <= S0;
         det_pulse <= 1'b0;
         det_count <= '0;
         bit_count <= '0;
      end else begin
         state_q   <= state_d;
         det_pulse <= nxtout;
         if (nxtout && (det_count != {CNT_W{1'b1}})) begin
            det_count <= det_count + 1'b1;
         end
         if (fire) begin
            bit_count <= bit_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl
// Drives a default-width (CNT_W=8) and a narrow (CNT_W=2) instance with the
// same stimulus and compares both against a history-based reference model.
module tb_seq_detect_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic in = 1'b0;
   logic clear = 1'b0;

   logic       in_ready8, nxtout8, det_pulse8;
   logic [1:0] currstate8;
   logic [7:0] det_count8, bit_count8;
   logic       in_ready2, nxtout2, det_pulse2;
   logic [1:0] currstate2;
   logic [1:0] det_count2, bit_count2;

   int checks = 0;
   int failures = 0;

`ifdef SEQDET_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   always #5 clk = ~clk;

   seq_detect_ctrl dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in        (in),
      .in_ready  (in_ready8),
      .clear     (clear),
      .currstate (currstate8),
      .nxtout    (nxtout8),
      .det_pulse (det_pulse8),
      .det_count (det_count8),
      .bit_count (bit_count8)
   );

   seq_detect_ctrl #(.CNT_W(2)) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in        (in),
      .in_ready  (in_ready2),
      .clear     (clear),
      .currstate (currstate2),
      .nxtout    (nxtout2),
      .det_pulse (det_pulse2),
      .det_count (det_count2),
      .bit_count (bit_count2)
   );

   // Reference model: recent consumed bits, how many of them may still be part
   // of a match, total detections and total consumed bits (unbounded).
   logic [3:0] m_last;
   int         m_hlen;
   int         m_det;
   int         m_bits;
   logic       m_pulse;

   task automatic model_reset();
      m_last  = 4'b0000;
      m_hlen  = 0;
      m_det   = 0;
      m_bits  = 0;
      m_pulse = 1'b0;
   endtask

   // Longest prefix of 1011 that ends the usable history.
   function automatic logic [1:0] exp_state();
      if (m_hlen >= 3 && m_last[2:0] == 3'b101) return 2'd3;
      if (m_hlen >= 2 && m_last[1:0] == 2'b10) return 2'd2;
      if (m_hlen >= 1 && m_last[0] == 1'b1) return 2'd1;
      return 2'd0;
   endfunction

   function automatic int sat(int v, int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_regs();
      chk("currstate8", 32'(currstate8), 32'(exp_state()));
      chk("currstate2", 32'(currstate2), 32'(exp_state()));
      chk("det_pulse8", 32'(det_pulse8), 32'(m_pulse));
      chk("det_pulse2", 32'(det_pulse2), 32'(m_pulse));
      chk("det_count8", 32'(det_count8), 32'(sat(m_det, 255)));
      chk("det_count2", 32'(det_count2), 32'(sat(m_det, 3)));
      chk("bit_count8", 32'(bit_count8), 32'(m_bits % 256));
      chk("bit_count2", 32'(bit_count2), 32'(m_bits % 4));
   endtask

   // One clock cycle: drive at negedge, check combinational outputs, then
   // check registered outputs just after the rising edge.
   task automatic cyc(input logic v, input logic b, input logic c);
      logic fire;
      logic det;
      @(negedge clk);
      in_valid = v;
      in       = b;
      clear    = c;
      #1;
      fire = v && !c;
      det  = fire && (m_hlen >= 3) && ({m_last[2:0], b} == 4'b1011);
      chk("in_ready8", 32'(in_ready8), 32'(!c));
      chk("in_ready2", 32'(in_ready2), 32'(!c));
      chk("nxtout8", 32'(nxtout8), 32'(det));
      chk("nxtout2", 32'(nxtout2), 32'(det));
      @(posedge clk);
      #1;
      if (c) begin
         model_reset();
      end else begin
         if (fire) begin
            m_last = {m_last[2:0], b};
            m_hlen++;
            m_bits++;
            if (det) begin
               m_det++;
               if (!OVL) m_hlen = 0;
            end
         end
         m_pulse = det;
      end
      check_regs();
   endtask

   task automatic stream(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) cyc(1'b1, bits[i], 1'b0);
   endtask

   initial begin
      model_reset();
      in_valid = 1'b1;
      in       = 1'b1;
      #12;
      // Held in reset: registers at reset values, ready high, no detect.
      check_regs();
      chk("rst_in_ready", 32'(in_ready8), 32'd1);
      chk("rst_nxtout", 32'(nxtout8), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;

      // Basic 1011.
      stream(32'b1011, 4);
      chk("first_det_count", 32'(det_count8), 32'd1);
      chk("first_bit_count", 32'(bit_count8), 32'd4);
      cyc(1'b0, 1'b0, 1'b0);

      // Overlap-sensitive stream.
      cyc(1'b0, 1'b0, 1'b1);
      stream(32'b1011011, 7);
      chk("overlap_count", 32'(det_count8), OVL ? 32'd2 : 32'd1);

      // 101011: falls back from S3 to S2, then detects.
      cyc(1'b0, 1'b0, 1'b1);
      stream(32'b101011, 6);

      // Stall in S3 with in toggling, then detect.
      cyc(1'b0, 1'b0, 1'b1);
      stream(32'b101, 3);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);

      // Clear wins over a completing bit in S3.
      cyc(1'b0, 1'b0, 1'b1);
      stream(32'b101, 3);
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);

      // Eight back-to-back matches: narrow counter saturates, bit counter wraps.
      cyc(1'b0, 1'b0, 1'b1);
      stream(32'hBBBB_BBBB, 32);
      chk("sat_det_count2", 32'(det_count2), 32'd3);
      chk("wrap_bit_count2", 32'(bit_count2), 32'd0);

      // Asynchronous reset mid-pattern.
      stream(32'b101, 3);
      @(negedge clk);
      in_valid = 1'b1;
      in       = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_regs();
      chk("rst_mid_nxtout", 32'(nxtout8), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 39) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Sequential controller that drives the Mealy output function of the serial pattern detector. It owns the 2-bit state register, the next-state logic, a handshake on the serial input bit, and detection bookkeeping. Detected pattern is `1011`, MSB first in arrival order. It sits between the serial bit source and downstream logic that consumes detection pulses and counts.

## Interface
Parameters:
- `CNT_W`, default 8: width of `det_count` and `bit_count`.

Ports:
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: the `in` bit is presented this cycle.
- `in`, input, 1: serial data bit.
- `in_ready`, output, 1: block accepts a bit. A bit is consumed when `in_valid & in_ready`.
- `clear`, input, 1: synchronous clear of state and counters.
- `currstate`, output, 2: current FSM state.
- `nxtout`, output, 1: combinational Mealy detect. It is high when a consumed bit completes the pattern.
- `det_pulse`, output, 1: registered copy of `nxtout`.
- `det_count`, output, `CNT_W`: number of detections, saturating.
- `bit_count`, output, `CNT_W`: number of bits consumed, wrapping.

## Operation
States, encoded in `currstate`:
- S0 = 2'b00: no prefix matched.
- S1 = 2'b01: matched `1`.
- S2 = 2'b10: matched `10`.
- S3 = 2'b11: matched `101`.

Transitions apply only on a consumed bit:
- S0: `in=1` goes to S1; `in=0` goes to S0.
- S1: `in=1` goes to S1; `in=0` goes to S2.
- S2: `in=1` goes to S3; `in=0` goes to S0.
- S3: `in=0` goes to S2.
- S3, `in=1`: this is a detection. The next state depends on the overlap setting (see Configuration).

Output and counters:
- `nxtout = in_valid & in_ready & (currstate==S3) & in`.
- No consumed bit: the state holds and `nxtout` = 0.
- `in_ready` = `~clear`. It is 0 during a clear cycle; bits offered in that cycle are not consumed.
- `det_count` increments on each detection and saturates at 2^`CNT_W`-1.
- `bit_count` increments on each consumed bit and wraps from 2^`CNT_W`-1 to 0.

## Timing
- Reset values: `currstate`=S0, `det_pulse`=0, `det_count`=0, `bit_count`=0.
- While reset is held, `in_ready`=1 if `clear`=0, and `nxtout`=0 because the state is S0.
- `nxtout` has zero latency: it is valid in the same cycle as the completing bit.
- `det_pulse`, `det_count` and `currstate` update at the next rising edge, one cycle after the completing bit.
- One bit is consumed per cycle at most, so back-to-back bits run at full rate.
- `clear` takes priority over a simultaneous `in_valid`. The next edge gives state S0 and both counters 0. `det_pulse` is 0 in the cycle after a clear.
- Reset asserted mid-stream returns the block to reset values immediately. The partial prefix is lost.
- Detection with `det_count` at its maximum: the count stays at maximum, and `nxtout` and `det_pulse` still assert.

## Configuration
- `SEQDET_OVERLAP_EN` defined: S3 with `in=1` goes to S1. The trailing `1` is reused, so stream `1011011` gives two detections.
- `SEQDET_OVERLAP_EN` undefined: S3 with `in=1` goes to S0. Detections do not overlap, so stream `1011011` gives one detection.
- The S3/`in=0` to S2 transition is identical in both builds.

## Structure
Shared package `seq_detect_pkg` holds:
- the state typedef and the constants S0 to S3;
- the pattern constant `4'b1011`;
- the default value of `CNT_W`.

Sub-module `seq_out_fn` is purely combinational. It maps (`in`, `currstate`) to `nxtout` and is instantiated once. The next-state logic stays in the top module.

## Test plan
- Reset, then `in_valid`=1 with stream 1,0,1,1 -> `nxtout`=1 on the 4th bit; `det_pulse`=1 one cycle later; `det_count`=1; `bit_count`=4; final `currstate`=01 (overlap build) or 00 (non-overlap build).
- Stream 1,0,1,1,0,1,1 -> `det_count`=2 with `SEQDET_OVERLAP_EN` defined; 1 without.
- Stream 1,0,1,0,1,1 -> `currstate` sequence 01,10,11,10,11, then a detection on the 6th bit; `det_count`=1.
- `in_valid` deasserted for 3 cycles while in S3 -> `currstate` holds at 11, `nxtout` stays 0, `bit_count` unchanged. A following `in=1` detects.
- `clear` and `in_valid`=1 with `in`=1 together while in S3 -> no detection; next cycle `currstate`=00 and both counters 0.
- `CNT_W`=2, six overlapping detections -> `det_count` stays at 3. 16 consumed bits -> `bit_count` wraps to 0. `rst_n` pulsed low mid-pattern -> all outputs return to reset values asynchronously.
